// File: rtl/assoc_cache_wb.sv
// Set-associative write-back, write-allocate cache with true-LRU replacement.
// Define CACHE_STATS_EN to add saturating hit/miss counters (hit_cnt_o, miss_cnt_o).
module assoc_cache_wb #(
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WAYS        = 4,
    parameter int unsigned SETS        = 16,
    parameter int unsigned BLOCK_WORDS = 4
) (
    input  logic                                      clk_i,
    input  logic                                      reset_ni,
    input  logic                                      cpu_read_i,
    input  logic                                      cpu_write_i,
    input  logic [ADDR_W-1:0]                         cpu_addr_i,
    input  logic [WORD_W-1:0]                         cpu_wdata_i,
    output logic [WORD_W-1:0]                         cpu_rdata_o,
    output logic                                      cpu_busy_o,
`ifdef CACHE_STATS_EN
    output logic [31:0]                               hit_cnt_o,
    output logic [31:0]                               miss_cnt_o,
`endif
    output logic                                      mem_read_o,
    output logic                                      mem_write_o,
    output logic [ADDR_W-$clog2(BLOCK_WORDS)-3:0]     mem_addr_o,
    output logic [BLOCK_WORDS*WORD_W-1:0]             mem_wdata_o,
    input  logic [BLOCK_WORDS*WORD_W-1:0]             mem_rdata_i,
    input  logic                                      mem_ack_i
);

    localparam int unsigned OFF_W   = $clog2(BLOCK_WORDS);
    localparam int unsigned OFF_WS  = (OFF_W > 0) ? OFF_W : 1;
    localparam int unsigned IDX_W   = $clog2(SETS);
    localparam int unsigned WAY_W   = $clog2(WAYS);
    localparam int unsigned LINE_AW = ADDR_W - OFF_W - 2;
    localparam int unsigned TAG_W   = LINE_AW - IDX_W;
    localparam int unsigned LINE_W  = BLOCK_WORDS * WORD_W;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITEBACK = 2'd1;
    localparam logic [1:0] ST_REFILL    = 2'd2;
    localparam logic [1:0] ST_UPDATE    = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [LINE_AW-1:0] req_line_q;
    logic [WAY_W-1:0]   victim_q;
    logic               just_updated_q;

    logic               valid_q [SETS][WAYS];
    logic               dirty_q [SETS][WAYS];
    logic [WAY_W-1:0]   age_q   [SETS][WAYS];
    logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
    logic [LINE_W-1:0]  data_q  [SETS][WAYS];

    logic [LINE_AW-1:0] cpu_line;
    logic [IDX_W-1:0]   cpu_idx;
    logic [TAG_W-1:0]   cpu_tag;
    logic [OFF_WS-1:0]  cpu_word;
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               unused_addr_bits;

    assign cpu_line         = cpu_addr_i[ADDR_W-1:OFF_W+2];
    assign cpu_idx          = cpu_line[IDX_W-1:0];
    assign cpu_tag          = cpu_line[LINE_AW-1:IDX_W];
    assign req_idx          = req_line_q[IDX_W-1:0];
    assign req_tag          = req_line_q[LINE_AW-1:IDX_W];
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    generate
        if (OFF_W > 0) begin : g_word_sel
            assign cpu_word = cpu_addr_i[OFF_W+1:2];
        end else begin : g_single_word
            assign cpu_word = '0;
        end
    endgenerate

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim;
    logic [WAY_W-1:0] victim_inv;
    logic [WAY_W-1:0] victim_lru;
    logic             any_invalid;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[cpu_idx][w] && (tag_q[cpu_idx][w] == cpu_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Prefer the lowest-numbered empty way; otherwise evict the oldest.
    always_comb begin
        any_invalid = 1'b0;
        victim_inv  = '0;
        victim_lru  = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!valid_q[cpu_idx][w] && !any_invalid) begin
                any_invalid = 1'b1;
                victim_inv  = WAY_W'(w);
            end
            if (age_q[cpu_idx][w] == WAY_W'(WAYS - 1)) begin
                victim_lru = WAY_W'(w);
            end
        end
        victim = any_invalid ? victim_inv : victim_lru;
    end

    logic idle;
    logic req;
    logic hit_acc;
    logic miss_cap;

    assign idle     = (state_q == ST_IDLE);
    assign req      = cpu_read_i | cpu_write_i;
    assign hit_acc  = idle && req && hit;
    assign miss_cap = idle && req && !hit;

    logic [LINE_W-1:0] sel_line;
    logic [WORD_W-1:0] rd_word;

    always_comb begin
        sel_line = data_q[cpu_idx][hit_way];
        rd_word  = '0;
        for (int unsigned b = 0; b < BLOCK_WORDS; b++) begin
            if (cpu_word == OFF_WS'(b)) begin
                rd_word = sel_line[b*WORD_W +: WORD_W];
            end
        end
    end

    assign cpu_rdata_o = (hit_acc && cpu_read_i && !cpu_write_i) ? rd_word : '0;
    // Gated by reset so a held miss request cannot raise busy while in reset.
    assign cpu_busy_o  = reset_ni && (!idle || miss_cap);

    assign mem_write_o = (state_q == ST_WRITEBACK);
    assign mem_read_o  = (state_q == ST_REFILL);

    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (state_q == ST_WRITEBACK) begin
            mem_addr_o  = {tag_q[req_idx][victim_q], req_idx};
            mem_wdata_o = data_q[req_idx][victim_q];
        end else if (state_q == ST_REFILL) begin
            mem_addr_o  = req_line_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (miss_cap) begin
                    state_d = (valid_q[cpu_idx][victim] && dirty_q[cpu_idx][victim])
                            ? ST_WRITEBACK : ST_REFILL;
                end
            end
            ST_WRITEBACK: if (mem_ack_i) state_d = ST_REFILL;
            ST_REFILL:    if (mem_ack_i) state_d = ST_UPDATE;
            default:      state_d = ST_IDLE;
        endcase
    end

    logic             lru_en;
    logic [IDX_W-1:0] lru_set;
    logic [WAY_W-1:0] lru_way;
    logic [WAY_W-1:0] lru_old;
    logic [WAY_W-1:0] age_next [WAYS];

    assign lru_en  = hit_acc || (state_q == ST_UPDATE);
    assign lru_set = hit_acc ? cpu_idx : req_idx;
    assign lru_way = hit_acc ? hit_way : victim_q;

    // Ages younger than the accessed way shift back by one, keeping a permutation.
    always_comb begin
        lru_old = age_q[lru_set][lru_way];
        for (int unsigned w = 0; w < WAYS; w++) begin
            age_next[w] = age_q[lru_set][w];
            if (WAY_W'(w) == lru_way) begin
                age_next[w] = '0;
            end else if (age_q[lru_set][w] < lru_old) begin
                age_next[w] = age_q[lru_set][w] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q        <= ST_IDLE;
            req_line_q     <= '0;
            victim_q       <= '0;
            just_updated_q <= 1'b0;
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            state_q        <= state_d;
            just_updated_q <= (state_q == ST_UPDATE);
            if (miss_cap) begin
                req_line_q <= cpu_line;
                victim_q   <= victim;
            end
            if (hit_acc && cpu_write_i) begin
                dirty_q[cpu_idx][hit_way] <= 1'b1;
            end
            if (state_q == ST_UPDATE) begin
                valid_q[req_idx][victim_q] <= 1'b1;
                dirty_q[req_idx][victim_q] <= 1'b0;
            end
            if (lru_en) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    age_q[lru_set][w] <= age_next[w];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (hit_acc && cpu_write_i) begin
            for (int unsigned b = 0; b < BLOCK_WORDS; b++) begin
                if (cpu_word == OFF_WS'(b)) begin
                    data_q[cpu_idx][hit_way][b*WORD_W +: WORD_W] <= cpu_wdata_i;
                end
            end
        end
        if ((state_q == ST_REFILL) && mem_ack_i) begin
            data_q[req_idx][victim_q] <= mem_rdata_i;
        end
        if (state_q == ST_UPDATE) begin
            tag_q[req_idx][victim_q] <= req_tag;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // The re-evaluated hit right after a refill is the tail of a miss, not a new hit.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_acc && !just_updated_q && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_cap && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    logic unused_just_updated;
    assign unused_just_updated = just_updated_q;
`endif

endmodule
